apb_master_arbiter: RTL and testbench

Shares one APB master port between NB_REQ internal requesters using round-robin arbitration. Each requester uses a simple req/gnt/rvalid handshake. The block sequences the APB SETUP and ACCESS phases and returns read data and errors to the winning requester. An optional access timeout guards against a slave that never raises pready. Its APB master port drives the slave port of an apb_node.

---
 rtl/apb_arb_pkg.sv | 24 ++
 rtl/apb_rr_arbiter.sv | 41 ++++
 rtl/apb_master_arbiter.sv | 166 ++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and sizing helpers for the APB master arbiter.
//   apb_arb_state_e : transfer sequencer states
//   tmo_cnt_width() : width of the ACCESS-phase timeout counter (min 1)
//   idx_width()     : width of a requester index (min 1)
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_arb_state_e;

  function automatic int unsigned tmo_cnt_width(input int unsigned timeout_cycles);
    int unsigned w;
    w = $clog2(timeout_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : highest-priority requester index (owned by the caller)
//   gnt   : one-hot winner
//   idx   : binary winner index
//   valid : at least one request present
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NB_REQ = 4,
  localparam int unsigned IDX_W = idx_width(NB_REQ)
) (
  input  logic [NB_REQ-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NB_REQ-1:0] gnt,
  output logic [IDX_W-1:0]  idx,
  output logic              valid
);

  logic [NB_REQ-1:0] rot;
  int unsigned       cand;

  // Scan from ptr upwards with wrap; first set request wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    rot   = '0;
    cand  = 0;
    for (int unsigned i = 0; i < NB_REQ; i++) begin
      cand = (32'(ptr) + i) % NB_REQ;
      rot  = req >> cand;
      if (!valid && rot[0]) begin
        valid = 1'b1;
        gnt   = NB_REQ'(1) << cand;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between NB_REQ requesters (round robin).
//   clk_i, rst_i               : clock, synchronous active-high reset
//   req_i/we_i/addr_i/wdata_i  : per-requester request and fields
//   gnt_o                      : one-hot grant pulse (fields sampled this cycle)
//   rvalid_o/rdata_o/err_o     : one-hot completion with shared read data / error
//   psel_o..pwdata_o           : APB master request signals
//   prdata_i/pready_i/pslverr_i: APB slave response
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NB_REQ         = 4,
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [NB_REQ-1:0]                        req_i,
  input  logic [NB_REQ-1:0]                        we_i,
  input  logic [NB_REQ-1:0][APB_ADDR_WIDTH-1:0]    addr_i,
  input  logic [NB_REQ-1:0][APB_DATA_WIDTH-1:0]    wdata_i,
  output logic [NB_REQ-1:0]                        gnt_o,
  output logic [NB_REQ-1:0]                        rvalid_o,
  output logic [APB_DATA_WIDTH-1:0]                rdata_o,
  output logic                                     err_o,
  output logic                                     psel_o,
  output logic                                     penable_o,
  output logic                                     pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0]                paddr_o,
  output logic [APB_DATA_WIDTH-1:0]                pwdata_o,
  input  logic [APB_DATA_WIDTH-1:0]                prdata_i,
  input  logic                                     pready_i,
  input  logic                                     pslverr_i
);

  localparam int unsigned IDX_W    = idx_width(NB_REQ);
  localparam int unsigned CNT_W    = tmo_cnt_width(TIMEOUT_CYCLES);
  localparam int unsigned TMO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);

  apb_arb_state_e            state_q, state_d;
  logic [IDX_W-1:0]          ptr_q;
  logic [IDX_W-1:0]          idx_q;
  logic                      we_q;
  logic [APB_ADDR_WIDTH-1:0] addr_q;
  logic [APB_DATA_WIDTH-1:0] wdata_q;
  logic [APB_DATA_WIDTH-1:0] rdata_q;
  logic                      err_q;
  logic [CNT_W-1:0]          cnt_q;

  logic [NB_REQ-1:0]         arb_gnt;
  logic [IDX_W-1:0]          arb_idx;
  logic                      arb_valid;
  logic                      grant_c;
  logic                      timeout_c;
  logic [IDX_W-1:0]          ptr_next_c;

  apb_rr_arbiter #(.NB_REQ(NB_REQ)) u_rr (
    .req   (req_i),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // A request raised while reset is held must not produce a grant pulse.
  assign grant_c    = (state_q == IDLE) && arb_valid && !rst_i;
  assign timeout_c  = TMO_EN && (cnt_q == CNT_W'(TMO_LAST));
  assign ptr_next_c = (arb_idx == IDX_W'(NB_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_c) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready_i || timeout_c) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; everything idles at zero outside its phase.
  always_comb begin
    gnt_o     = '0;
    rvalid_o  = '0;
    rdata_o   = '0;
    err_o     = 1'b0;
    psel_o    = 1'b0;
    penable_o = 1'b0;
    pwrite_o  = 1'b0;
    paddr_o   = '0;
    pwdata_o  = '0;
    case (state_q)
      IDLE: begin
        if (grant_c) gnt_o = arb_gnt;
      end
      SETUP: begin
        psel_o   = 1'b1;
        pwrite_o = we_q;
        paddr_o  = addr_q;
        pwdata_o = wdata_q;
      end
      ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
        pwrite_o  = we_q;
        paddr_o   = addr_q;
        pwdata_o  = wdata_q;
      end
      RESP: begin
        rvalid_o = NB_REQ'(1) << idx_q;
        rdata_o  = rdata_q;
        err_o    = err_q;
      end
      default: ;
    endcase
  end

  // Request capture, round-robin pointer, response capture and timeout count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_c) begin
            idx_q   <= arb_idx;
            we_q    <= we_i[arb_idx];
            addr_q  <= addr_i[arb_idx];
            wdata_q <= wdata_i[arb_idx];
            ptr_q   <= ptr_next_c;
            cnt_q   <= '0;
          end
        end
        ACCESS: begin
          // pready takes precedence over an expiring timeout.
          if (pready_i) begin
            rdata_q <= we_q ? '0 : prdata_i;
            err_q   <= pslverr_i;
          end else if (timeout_c) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
module tb_apb_master_arbiter;

  localparam int NB = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic                   clk;
  logic                   rst;
  logic [NB-1:0]          req, we;
  logic [NB-1:0][AW-1:0]  addr;
  logic [NB-1:0][DW-1:0]  wdata;
  logic [NB-1:0]          gnt, rvalid;
  logic [DW-1:0]          rdata;
  logic                   err;
  logic                   psel, pen, pwrite;
  logic [AW-1:0]          paddr;
  logic [DW-1:0]          pwdata, prdata;
  logic                   pready, pslverr;

  apb_master_arbiter #(
    .NB_REQ(NB), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .psel_o(psel), .penable_o(pen), .pwrite_o(pwrite), .paddr_o(paddr), .pwdata_o(pwdata),
    .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // One transfer at a time, described by its age in cycles since the grant.
  bit             m_busy, m_resp;
  int             m_age, m_win, m_ptr;
  logic           m_we, m_err;
  logic [AW-1:0]  m_addr;
  logic [DW-1:0]  m_wdata, m_rdata;
  logic [NB-1:0]  granted_mask;

  function automatic int rr_pick(input logic [NB-1:0] r, input int p);
    for (int k = 0; k < NB; k++) begin
      int c;
      c = (p + k) % NB;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    granted_mask = '0;
    w = -1;
    if (rst) begin
      m_busy = 1'b0; m_resp = 1'b0; m_ptr = 0; m_age = 0;
    end else if (m_resp) begin
      m_resp = 1'b0; m_busy = 1'b0;
    end else if (m_busy) begin
      if (m_age == 1) m_age = 2;
      else if (pready) begin
        m_resp = 1'b1; m_rdata = m_we ? '0 : prdata; m_err = pslverr;
      end else if (TO != 0 && (m_age - 1) == TO) begin
        m_resp = 1'b1; m_rdata = '0; m_err = 1'b1;
      end else m_age++;
    end else begin
      w = rr_pick(req, m_ptr);
      if (w >= 0) begin
        m_win = w; m_we = we[w]; m_addr = addr[w]; m_wdata = wdata[w];
        m_ptr = (w + 1) % NB; m_busy = 1'b1; m_age = 1;
        granted_mask[w] = 1'b1;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  logic [NB-1:0] e_gnt, e_rv;
  logic [DW-1:0] e_rdata, e_pwdata;
  logic [AW-1:0] e_paddr;
  logic          e_err, e_psel, e_pen, e_pwrite;

  always @(negedge clk) begin
    int w;
    if (chk_en) begin
      e_gnt = '0; e_rv = '0; e_rdata = '0; e_err = 1'b0;
      e_psel = 1'b0; e_pen = 1'b0; e_pwrite = 1'b0; e_paddr = '0; e_pwdata = '0;
      w = -1;
      if (m_resp) begin
        e_rv = NB'(1) << m_win; e_rdata = m_rdata; e_err = m_err;
      end else if (m_busy) begin
        e_psel = 1'b1; e_pen = (m_age >= 2); e_pwrite = m_we; e_paddr = m_addr; e_pwdata = m_wdata;
      end else if (!rst) begin
        w = rr_pick(req, m_ptr);
        if (w >= 0) e_gnt = NB'(1) << w;
      end
      check("model_gnt",     64'(gnt),    64'(e_gnt));
      check("model_rvalid",  64'(rvalid), 64'(e_rv));
      check("model_rdata",   64'(rdata),  64'(e_rdata));
      check("model_err",     64'(err),    64'(e_err));
      check("model_psel",    64'(psel),   64'(e_psel));
      check("model_penable", 64'(pen),    64'(e_pen));
      check("model_pwrite",  64'(pwrite), 64'(e_pwrite));
      check("model_paddr",   64'(paddr),  64'(e_paddr));
      check("model_pwdata",  64'(pwdata), 64'(e_pwdata));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit chk);
    rst = 1'b1; req = '0; pready = 1'b0; pslverr = 1'b0;
    tick();
    if (chk) begin
      @(negedge clk);
      check("rst_gnt",     64'(gnt),    64'(0));
      check("rst_rvalid",  64'(rvalid), 64'(0));
      check("rst_rdata",   64'(rdata),  64'(0));
      check("rst_err",     64'(err),    64'(0));
      check("rst_psel",    64'(psel),   64'(0));
      check("rst_penable", 64'(pen),    64'(0));
      check("rst_pwrite",  64'(pwrite), 64'(0));
      check("rst_paddr",   64'(paddr),  64'(0));
      check("rst_pwdata",  64'(pwdata), 64'(0));
    end
    tick();
    rst = 1'b0;
  endtask

  // Runs one transfer already requested by 'who'. pready rises on ACCESS cycle
  // ready_at (0 = never). Returns at the negedge of the rvalid cycle.
  task automatic run_xfer(input int ready_at, input logic slverr, input logic [NB-1:0] who,
                          input logic [AW-1:0] x_addr, input logic [DW-1:0] x_wdata, input logic x_we,
                          output int n_acc, output int setup_cyc, output int acc_cyc, output int rv_cyc,
                          output logic [NB-1:0] gnt0, output logic [NB-1:0] rv,
                          output logic [DW-1:0] rd, output logic e);
    n_acc = 0; setup_cyc = -1; acc_cyc = -1; rv_cyc = -1;
    gnt0 = '0; rv = '0; rd = '0; e = 1'b0;
    pready = 1'b0; pslverr = slverr;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (cyc == 0) gnt0 = gnt;
      if (psel && !pen && setup_cyc < 0) setup_cyc = cyc;
      if (psel) begin
        check("xfer_paddr",  64'(paddr),  64'(x_addr));
        check("xfer_pwdata", 64'(pwdata), 64'(x_wdata));
        check("xfer_pwrite", 64'(pwrite), 64'(x_we));
      end
      if (psel && pen) begin
        n_acc++;
        if (acc_cyc < 0) acc_cyc = cyc;
      end
      if (rvalid != '0) begin
        rv = rvalid; rd = rdata; e = err; rv_cyc = cyc;
        break;
      end
      tick();
      if (cyc == 0) req = req & ~who;
      pready = (ready_at != 0) && (cyc + 1 == ready_at + 1);
    end
    pready = 1'b0;
  endtask

  task automatic drive_random(input int rate);
    for (int i = 0; i < NB; i++) begin
      if (granted_mask[i] || !req[i]) begin
        if ($urandom_range(0, 2) == 0) begin
          req[i] = 1'b1; we[i] = 1'($urandom_range(0, 1));
          addr[i] = $urandom; wdata[i] = $urandom;
        end else req[i] = 1'b0;
      end else if ($urandom_range(0, 39) == 0) req[i] = 1'b0;
    end
    pready  = (int'($urandom_range(0, 99)) < rate);
    prdata  = $urandom;
    pslverr = ($urandom_range(0, 3) == 0);
    rst     = ($urandom_range(0, 499) == 0);
  endtask

  // ---------------- main sequence ----------------
  int            n_acc, setup_cyc, acc_cyc, rv_cyc;
  logic [NB-1:0] gnt0, rv;
  logic [DW-1:0] rd;
  logic          e;
  int            g_idx[8];
  int            g_cyc[8];
  int            n_g;
  bit            seen2;
  int            rate;

  initial begin
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    tick();
    chk_en = 1'b1;

    // Single zero-wait read.
    do_reset(1'b1);
    req = 4'b0001; we = '0; addr[0] = 32'h0000_0100; wdata[0] = 32'h11; prdata = 32'hDEAD_BEEF;
    run_xfer(1, 1'b0, 4'b0001, 32'h0000_0100, 32'h11, 1'b0,
             n_acc, setup_cyc, acc_cyc, rv_cyc, gnt0, rv, rd, e);
    check("t1_gnt",       64'(gnt0),      64'(4'b0001));
    check("t1_setup_cyc", 64'(setup_cyc), 64'(1));
    check("t1_acc_cyc",   64'(acc_cyc),   64'(2));
    check("t1_rv_cyc",    64'(rv_cyc),    64'(3));
    check("t1_rvalid",    64'(rv),        64'(4'b0001));
    check("t1_rdata",     64'(rd),        64'(32'hDEAD_BEEF));
    check("t1_err",       64'(e),         64'(0));

    // All requesters held high: strict rotation, one grant per 4 cycles.
    do_reset(1'b0);
    req = 4'b1111; we = '0; pready = 1'b1; prdata = 32'h0BAD_F00D;
    for (int k = 0; k < NB; k++) begin addr[k] = AW'(32'h100 * k); wdata[k] = DW'(k); end
    n_g = 0;
    for (int cyc = 0; cyc < 60 && n_g < 8; cyc++) begin
      @(negedge clk);
      if (gnt != '0) begin
        check("t2_onehot", 64'($countones(gnt)), 64'(1));
        g_idx[n_g] = $clog2(gnt); g_cyc[n_g] = cyc; n_g++;
      end
      tick();
    end
    req = '0;
    check("t2_count", 64'(n_g), 64'(8));
    for (int k = 0; k < 8; k++) begin
      if (k < n_g) begin
        check("t2_order", 64'(g_idx[k]), 64'(k % 4));
        if (k > 0) check("t2_spacing", 64'(g_cyc[k] - g_cyc[k-1]), 64'(4));
      end
    end
    repeat (4) tick();

    // Write with 3 wait states.
    do_reset(1'b0);
    req = 4'b0100; we = 4'b0100; addr[2] = 32'h1A10_0004; wdata[2] = 32'h55; prdata = 32'hFFFF_FFFF;
    run_xfer(4, 1'b0, 4'b0100, 32'h1A10_0004, 32'h55, 1'b1,
             n_acc, setup_cyc, acc_cyc, rv_cyc, gnt0, rv, rd, e);
    check("t3_gnt",    64'(gnt0),   64'(4'b0100));
    check("t3_n_acc",  64'(n_acc),  64'(4));
    check("t3_rv_cyc", 64'(rv_cyc), 64'(6));
    check("t3_rvalid", 64'(rv),     64'(4'b0100));
    check("t3_rdata",  64'(rd),     64'(0));
    check("t3_err",    64'(e),      64'(0));

    // Timeout with pready stuck low, then a normal transfer.
    do_reset(1'b0);
    req = 4'b0010; we = '0; addr[1] = 32'h2000; wdata[1] = 32'h7; prdata = 32'hA5A5_A5A5;
    run_xfer(0, 1'b1, 4'b0010, 32'h2000, 32'h7, 1'b0,
             n_acc, setup_cyc, acc_cyc, rv_cyc, gnt0, rv, rd, e);
    check("t4_n_acc",  64'(n_acc), 64'(8));
    check("t4_rvalid", 64'(rv),    64'(4'b0010));
    check("t4_err",    64'(e),     64'(1));
    check("t4_rdata",  64'(rd),    64'(0));
    tick();
    req = 4'b1000; addr[3] = 32'h3000; wdata[3] = 32'h9; prdata = 32'h0000_1234;
    run_xfer(1, 1'b0, 4'b1000, 32'h3000, 32'h9, 1'b0,
             n_acc, setup_cyc, acc_cyc, rv_cyc, gnt0, rv, rd, e);
    check("t4b_rvalid", 64'(rv), 64'(4'b1000));
    check("t4b_rdata",  64'(rd), 64'(32'h1234));
    check("t4b_err",    64'(e),  64'(0));

    // pready with pslverr on the last timeout cycle: pready wins.
    do_reset(1'b0);
    req = 4'b0001; we = '0; addr[0] = 32'h40; wdata[0] = 32'h0; prdata = 32'hCAFE_0001;
    run_xfer(8, 1'b1, 4'b0001, 32'h40, 32'h0, 1'b0,
             n_acc, setup_cyc, acc_cyc, rv_cyc, gnt0, rv, rd, e);
    check("t5_n_acc",  64'(n_acc), 64'(8));
    check("t5_rvalid", 64'(rv),    64'(4'b0001));
    check("t5_err",    64'(e),     64'(1));
    check("t5_rdata",  64'(rd),    64'(32'hCAFE_0001));
    tick();

    // Reset during ACCESS of requester 1; pointer must return to 0.
    do_reset(1'b0);
    req = 4'b0010; we = '0; addr[1] = 32'h500; pready = 1'b0; pslverr = 1'b0;
    @(negedge clk);
    check("t6_gnt1", 64'(gnt), 64'(4'b0010));
    tick(); req = '0;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("t6_in_access", 64'({psel, pen}), 64'(2'b11));
    tick(); rst = 1'b1;
    @(negedge clk);
    tick(); rst = 1'b0; req = 4'b0110; addr[2] = 32'h600;
    @(negedge clk);
    check("t6_psel",   64'(psel),   64'(0));
    check("t6_pen",    64'(pen),    64'(0));
    check("t6_rvalid", 64'(rvalid), 64'(0));
    check("t6_gnt",    64'(gnt),    64'(4'b0010));
    tick(); req = 4'b0100; pready = 1'b1;
    seen2 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (gnt[2]) seen2 = 1'b1;
      tick();
      if (seen2) req = '0;
    end
    check("t6_req2_served", 64'(seen2), 64'(1));

    // Randomised traffic against the model.
    do_reset(1'b0);
    rate = 100;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 250 == 0) begin
        case ($urandom_range(0, 3))
          0:       rate = 100;
          1:       rate = 60;
          2:       rate = 25;
          default: rate = 0;
        endcase
      end
      tick();
      drive_random(rate);
    end
    rst = 1'b0; req = '0;
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
